// File: rtl/dsp_muladd_arbiter.sv
// dsp_muladd_arbiter: round-robin sharing of one P = A*B + C core between
// N_REQ requesters, with a tag pipeline that returns each result to its
// owner and a drain handshake for upstream mode switches.

package PARAMS_BN254_d0;
  parameter int K = 16;  // A operand width (<= 27)
  parameter int L = 16;  // B operand width (<= 18)
endpackage

// Pipelined multiply-add core: out_s = a*b + c, LATENCY cycles after the
// operands are presented. Data path only, no reset needed.
module DSP_muladd #(
  parameter int LATENCY = 3
) (
  input  logic        clk,
  input  logic [26:0] a,
  input  logic [17:0] b,
  input  logic [47:0] c,
  output logic [47:0] out_s
);
  logic [LATENCY-1:0][47:0] p;
  logic [47:0]              prod;

  assign prod = {21'd0, a} * {30'd0, b};

  // First stage computes, the rest only delay.
  always_ff @(posedge clk) begin
    p[0] <= prod + c;
    for (int i = 1; i < LATENCY; i++) p[i] <= p[i-1];
  end

  assign out_s = p[LATENCY-1];
endmodule

module dsp_muladd_arbiter
  import PARAMS_BN254_d0::*;
#(
  parameter int N_REQ   = 4,
  parameter int LATENCY = 3,
  parameter int ID_W    = $clog2(N_REQ)
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [N_REQ-1:0]               req_valid,
  output logic [N_REQ-1:0]               req_ready,
  input  logic [N_REQ*K-1:0]             req_a,
  input  logic [N_REQ*L-1:0]             req_b,
  input  logic [N_REQ*48-1:0]            req_c,
  output logic [N_REQ-1:0]               rsp_valid,
  output logic [ID_W-1:0]                rsp_id,
  output logic [47:0]                    rsp_data,
  input  logic                           drain_req,
  output logic                           drain_done,
  output logic [$clog2(LATENCY+1)-1:0]   inflight
);
  localparam int CW = $clog2(LATENCY+1);

  localparam logic [1:0] S_RUN   = 2'd0;
  localparam logic [1:0] S_DRAIN = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  logic [1:0]                  state;
  logic [ID_W-1:0]             rr_ptr;
  logic                        fire;
  logic [ID_W-1:0]             gid;
  logic [LATENCY-1:0]          vld_pipe;
  logic [LATENCY-1:0][ID_W-1:0] id_pipe;
  logic [CW-1:0]               cnt;
  logic [26:0]                 dsp_a;
  logic [17:0]                 dsp_b;
  logic [47:0]                 dsp_c;
  logic [47:0]                 dsp_out;
  logic                        last_vld;

  assign last_vld = vld_pipe[LATENCY-1];

  // Round-robin pick starting at rr_ptr; only issues in RUN with no drain pending.
  always_comb begin
    fire      = 1'b0;
    gid       = '0;
    req_ready = '0;
    if (rst_n && state == S_RUN && !drain_req) begin
      for (int k = 0; k < N_REQ; k++) begin
        if (!fire && req_valid[ID_W'((int'(rr_ptr) + k) % N_REQ)]) begin
          fire = 1'b1;
          gid  = ID_W'((int'(rr_ptr) + k) % N_REQ);
        end
      end
    end
    if (fire) req_ready[gid] = 1'b1;
  end

  // Operand mux; zeros when idle so nothing stale reaches the core.
  always_comb begin
    dsp_a = '0;
    dsp_b = '0;
    dsp_c = '0;
    if (fire) begin
      dsp_a = 27'(req_a[gid*K +: K]);
      dsp_b = 18'(req_b[gid*L +: L]);
      dsp_c = req_c[gid*48 +: 48];
    end
  end

  DSP_muladd #(.LATENCY(LATENCY)) u_dsp (
    .clk   (clk),
    .a     (dsp_a),
    .b     (dsp_b),
    .c     (dsp_c),
    .out_s (dsp_out)
  );

  // Pointer moves past the winner so every requester gets a turn.
  always_ff @(posedge clk) begin
    if (!rst_n)    rr_ptr <= '0;
    else if (fire) rr_ptr <= (int'(gid) == N_REQ-1) ? '0 : gid + 1'b1;
  end

  // Tag pipeline mirrors the core latency; no stall, so it always shifts.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_pipe <= '0;
      id_pipe  <= '0;
    end else begin
      vld_pipe[0] <= fire;
      id_pipe[0]  <= gid;
      for (int i = 1; i < LATENCY; i++) begin
        vld_pipe[i] <= vld_pipe[i-1];
        id_pipe[i]  <= id_pipe[i-1];
      end
    end
  end

  // Issued-but-unreturned count; a simultaneous issue and return cancel.
  always_ff @(posedge clk) begin
    if (!rst_n)                 cnt <= '0;
    else if (fire && !last_vld) cnt <= cnt + 1'b1;
    else if (!fire && last_vld) cnt <= cnt - 1'b1;
  end

  // Drain handshake: block issue, wait for empty, hold done until released.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= S_RUN;
    else begin
      case (state)
        S_RUN:   if (drain_req)  state <= S_DRAIN;
        S_DRAIN: if (cnt == '0)  state <= S_DONE;
        S_DONE:  if (!drain_req) state <= S_RUN;
        default:                 state <= S_RUN;
      endcase
    end
  end

  // Response strobe decoded from the last tag stage; quiet while in reset.
  always_comb begin
    rsp_valid = '0;
    if (rst_n && last_vld) rsp_valid[id_pipe[LATENCY-1]] = 1'b1;
  end

  assign rsp_id     = rst_n ? id_pipe[LATENCY-1] : '0;
  assign rsp_data   = dsp_out;
  assign drain_done = rst_n && (state == S_DONE);
  assign inflight   = cnt;
endmodule
